xbusdec: RTL and testbench

Parametrised data-bus interconnect between the controller's data port and N peripheral slaves. It supersedes the fixed combinational address decoder in the top level:
- per-slave base/size windows, fixed-priority overlap resolution;
- per-slave programmable wait states with a `data_ready` handshake;
- sticky, bus-readable error capture for unmapped accesses, with an interrupt output.

---
 rtl/xbusdec.sv | 163 ++++++++++++++++
 tb/tb_xbusdec.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/xbusdec.sv
// Data-bus interconnect: windowed slave decode with per-slave wait states,
// a two-word status window and sticky capture of unmapped accesses.
module xbusdec #(
    parameter int                        N_SLV     = 4,
    parameter int                        ADDR_W    = 16,
    parameter int                        DATA_W    = 32,
    parameter logic [N_SLV*ADDR_W-1:0]   SLV_BASE  = {16'h0800, 16'h0400, 16'h0100, 16'h0000},
    parameter logic [N_SLV*5-1:0]        SLV_SIZE  = {5'd10, 5'd0, 5'd4, 5'd8},
    parameter logic [N_SLV*4-1:0]        SLV_WAIT  = {4'd1, 4'd0, 4'd2, 4'd0},
    parameter logic [ADDR_W-1:0]         STAT_BASE = 16'h0FF0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      data_sel,
    input  logic                      data_we,
    input  logic [ADDR_W-1:0]         data_addr,
    input  logic [DATA_W-1:0]         data_to_wr,
    output logic [DATA_W-1:0]         data_to_rd,
    output logic                      data_ready,
    output logic [N_SLV-1:0]          slv_sel,
    output logic                      slv_we,
    output logic [ADDR_W-1:0]         slv_addr,
    output logic [DATA_W-1:0]         slv_data_in,
    input  logic [N_SLV*DATA_W-1:0]   slv_data_out,
    output logic                      err_irq
);

    localparam int                IDX_W   = (N_SLV > 1) ? $clog2(N_SLV) : 1;
    localparam logic [ADDR_W-1:0] STAT_HI = STAT_BASE + 1'b1;

    typedef enum logic [1:0] {IDLE, ACC, WAIT, RESP} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q;
    logic                we_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [IDX_W-1:0]    idx_q;
    logic                map_q;
    logic                stat_q;
    logic [3:0]          cnt_q;
    logic [N_SLV-1:0]    sel_q;
    logic                slv_we_q;
    logic                err_flag;
    logic [7:0]          err_cnt;
    logic [ADDR_W-1:0]   err_addr;

    logic                dec_hit;
    logic                dec_stat;
    logic [IDX_W-1:0]    dec_idx;
    logic [3:0]          dec_wait;
    logic                dec_map;
    logic [N_SLV-1:0]    dec_onehot;
    logic [DATA_W-1:0]   rd_mux;

    // Status window shadows everything; among slaves the lowest index wins.
    always_comb begin
        dec_hit  = 1'b0;
        dec_idx  = '0;
        dec_wait = '0;
        dec_stat = (data_addr == STAT_BASE) || (data_addr == STAT_HI);
        for (int i = 0; i < N_SLV; i++) begin
            if (!dec_hit && ((data_addr >> SLV_SIZE[i*5 +: 5]) ==
                             (SLV_BASE[i*ADDR_W +: ADDR_W] >> SLV_SIZE[i*5 +: 5]))) begin
                dec_hit  = 1'b1;
                dec_idx  = IDX_W'(i);
                dec_wait = SLV_WAIT[i*4 +: 4];
            end
        end
        dec_map    = dec_hit && !dec_stat;
        dec_onehot = dec_map ? (N_SLV'(1) << dec_idx) : '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (data_sel) state_d = ACC;
            ACC:  state_d = (cnt_q != 4'd0) ? WAIT : RESP;
            WAIT: if (cnt_q <= 4'd1) state_d = RESP;
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Request latches; slv_sel/slv_we are registered so they are high only in ACC.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q   <= '0;
            we_q     <= 1'b0;
            wdata_q  <= '0;
            idx_q    <= '0;
            map_q    <= 1'b0;
            stat_q   <= 1'b0;
            cnt_q    <= '0;
            sel_q    <= '0;
            slv_we_q <= 1'b0;
        end else begin
            sel_q    <= '0;
            slv_we_q <= 1'b0;
            case (state_q)
                IDLE: if (data_sel) begin
                    addr_q   <= data_addr;
                    we_q     <= data_we;
                    wdata_q  <= data_to_wr;
                    idx_q    <= dec_idx;
                    map_q    <= dec_map;
                    stat_q   <= dec_stat;
                    cnt_q    <= dec_map ? dec_wait : 4'd0;
                    sel_q    <= dec_onehot;
                    slv_we_q <= data_we;
                end
                WAIT: cnt_q <= cnt_q - 4'd1;
                default: ;
            endcase
        end
    end

    // Error bookkeeping happens as the access completes, so a clear-write never races it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_flag <= 1'b0;
            err_cnt  <= '0;
            err_addr <= '0;
        end else if (state_q == RESP) begin
            if (!map_q && !stat_q) begin
                err_flag <= 1'b1;
                if (!err_flag) err_addr <= addr_q;
                if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
            end else if (stat_q && we_q && (addr_q == STAT_BASE)) begin
                err_flag <= 1'b0;
                err_cnt  <= '0;
                err_addr <= '0;
            end
        end
    end

    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < N_SLV; i++) begin
            if (idx_q == IDX_W'(i)) rd_mux = slv_data_out[i*DATA_W +: DATA_W];
        end
        data_to_rd = '0;
        if ((state_q == RESP) && !we_q) begin
            if (map_q)
                data_to_rd = rd_mux;
            else if (stat_q)
                data_to_rd = (addr_q == STAT_BASE) ? DATA_W'({err_cnt, 7'b0, err_flag})
                                                   : DATA_W'(err_addr);
        end
    end

    assign data_ready  = (state_q == RESP);
    assign slv_sel     = sel_q;
    assign slv_we      = slv_we_q;
    assign slv_addr    = addr_q;
    assign slv_data_in = wdata_q;
    assign err_irq     = err_flag;

endmodule

// File: tb/tb_xbusdec.sv
// Bench for xbusdec: directed steps plus randomized accesses checked against
// an address-range model of the slave map and the error/status registers.
module tb_xbusdec;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          data_sel = 1'b0;
    logic          data_sel2 = 1'b0;
    logic          data_we = 1'b0;
    logic [15:0]   data_addr = '0;
    logic [31:0]   data_to_wr = '0;
    logic [127:0]  slv_data_out = '0;

    logic [31:0]   data_to_rd, d2_data_to_rd;
    logic          data_ready, d2_data_ready;
    logic [3:0]    slv_sel, d2_slv_sel;
    logic          slv_we, d2_slv_we;
    logic [15:0]   slv_addr, d2_slv_addr;
    logic [31:0]   slv_data_in, d2_slv_data_in;
    logic          err_irq, d2_err_irq;

    int n_cmp = 0;
    int n_fail = 0;

    int m_base [4] = '{32'h0000, 32'h0100, 32'h0400, 32'h0800};
    int m_size [4] = '{8, 4, 0, 10};
    int m_wait [4] = '{0, 2, 0, 1};
    logic [31:0] slave_word [4];
    bit          m_flag = 1'b0;
    int          m_cnt = 0;
    logic [15:0] m_addr = '0;

    always #5 clk = ~clk;

    xbusdec dut (
        .clk(clk), .rst(rst), .data_sel(data_sel), .data_we(data_we),
        .data_addr(data_addr), .data_to_wr(data_to_wr), .data_to_rd(data_to_rd),
        .data_ready(data_ready), .slv_sel(slv_sel), .slv_we(slv_we),
        .slv_addr(slv_addr), .slv_data_in(slv_data_in),
        .slv_data_out(slv_data_out), .err_irq(err_irq)
    );

    // Overlapping map: slaves 0 and 1 both based at 0x0100.
    xbusdec #(.SLV_BASE({16'h0800, 16'h0400, 16'h0100, 16'h0100})) dut2 (
        .clk(clk), .rst(rst), .data_sel(data_sel2), .data_we(data_we),
        .data_addr(data_addr), .data_to_wr(data_to_wr), .data_to_rd(d2_data_to_rd),
        .data_ready(d2_data_ready), .slv_sel(d2_slv_sel), .slv_we(d2_slv_we),
        .slv_addr(d2_slv_addr), .slv_data_in(d2_slv_data_in),
        .slv_data_out(slv_data_out), .err_irq(d2_err_irq)
    );

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // -2 = status window, -1 = unmapped, otherwise slave index
    function automatic int model_target(input logic [15:0] a);
        int ai, win, lo;
        ai = a;
        if (ai == 32'h0FF0 || ai == 32'h0FF1) return -2;
        for (int i = 0; i < 4; i++) begin
            win = 1 << m_size[i];
            lo  = (m_base[i] / win) * win;
            if (ai >= lo && ai < lo + win) return i;
        end
        return -1;
    endfunction

    task automatic apply_stimulus(input logic [15:0] addr, input logic we,
                                  input logic [31:0] wdata, input bit full);
        int t, w;
        logic [31:0] exp_rd;
        logic [3:0]  exp_sel;
        t = model_target(addr);
        w = (t >= 0) ? m_wait[t] : 0;
        exp_sel = (t >= 0) ? 4'(1 << t) : 4'b0;
        exp_rd = 32'h0;
        if (!we && t >= 0) exp_rd = slave_word[t];
        if (!we && t == -2) exp_rd = (addr == 16'h0FF0) ? 32'((m_cnt << 8) | int'(m_flag)) : {16'h0, m_addr};
        for (int i = 0; i < 4; i++) slv_data_out[i*32 +: 32] = slave_word[i];
        data_sel = 1'b1; data_addr = addr; data_we = we; data_to_wr = wdata;
        @(posedge clk); #1;
        data_sel = 1'b0; data_addr = 16'($urandom); data_we = 1'($urandom); data_to_wr = $urandom;
        if (full) begin
            check_output("acc_sel", {28'h0, slv_sel}, {28'h0, exp_sel});
            check_output("acc_ready", {31'h0, data_ready}, 32'h0);
            if (t >= 0) begin
                check_output("acc_addr", {16'h0, slv_addr}, {16'h0, addr});
                check_output("acc_we", {31'h0, slv_we}, {31'h0, we});
                check_output("acc_wdata", slv_data_in, wdata);
            end
        end
        for (int k = 0; k < w; k++) begin
            @(posedge clk); #1;
            if (full) begin
                check_output("wait_sel", {28'h0, slv_sel}, 32'h0);
                check_output("wait_ready", {31'h0, data_ready}, 32'h0);
            end
        end
        @(posedge clk); #1;
        check_output("resp_ready", {31'h0, data_ready}, 32'h1);
        check_output("resp_rdata", data_to_rd, exp_rd);
        if (full) check_output("resp_sel", {28'h0, slv_sel}, 32'h0);
        if (t == -1) begin
            if (!m_flag) m_addr = addr;
            m_flag = 1'b1;
            if (m_cnt < 255) m_cnt++;
        end else if (t == -2 && we && addr == 16'h0FF0) begin
            m_flag = 1'b0; m_cnt = 0; m_addr = '0;
        end
        @(posedge clk); #1;
        check_output("idle_ready", {31'h0, data_ready}, 32'h0);
        check_output("idle_rdata", data_to_rd, 32'h0);
        check_output("err_irq", {31'h0, err_irq}, {31'h0, m_flag});
    endtask

    task automatic check_all_zero(input string tag);
        check_output({tag, "_sel"}, {28'h0, slv_sel}, 32'h0);
        check_output({tag, "_ready"}, {31'h0, data_ready}, 32'h0);
        check_output({tag, "_rdata"}, data_to_rd, 32'h0);
        check_output({tag, "_we"}, {31'h0, slv_we}, 32'h0);
        check_output({tag, "_addr"}, {16'h0, slv_addr}, 32'h0);
        check_output({tag, "_wdata"}, slv_data_in, 32'h0);
        check_output({tag, "_irq"}, {31'h0, err_irq}, 32'h0);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL timeout observed=running expected=finished");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        int cls, i, win, lo;
        logic [15:0] a;
        for (int k = 0; k < 4; k++) slave_word[k] = $urandom;

        repeat (3) @(posedge clk);
        #1 check_all_zero("rst_hold");
        rst = 1'b1;
        #1 check_all_zero("rst_rel");

        $display("[TB] directed: slave0 write, slave1 read");
        apply_stimulus(16'h0013, 1'b1, 32'h12345678, 1'b1);
        slave_word[1] = 32'hCAFEF00D;
        apply_stimulus(16'h0105, 1'b0, 32'h0, 1'b1);

        $display("[TB] directed: unmapped capture and status reads");
        apply_stimulus(16'h0401, 1'b0, 32'h0, 1'b1);
        apply_stimulus(16'h0FF0, 1'b0, 32'h0, 1'b1);
        apply_stimulus(16'h0FF1, 1'b0, 32'h0, 1'b1);
        apply_stimulus(16'h2000, 1'b1, 32'hDEADBEEF, 1'b1);
        for (int k = 0; k < 300; k++)
            apply_stimulus(16'(32'h1000 + $urandom_range(0, 32'hEFFF)), 1'($urandom), $urandom, 1'b0);
        apply_stimulus(16'h0FF0, 1'b0, 32'h0, 1'b1);
        apply_stimulus(16'h0FF1, 1'b0, 32'h0, 1'b1);
        apply_stimulus(16'h0FF0, 1'b1, $urandom, 1'b1);
        apply_stimulus(16'h0FF0, 1'b0, 32'h0, 1'b1);
        apply_stimulus(16'h0FF1, 1'b0, 32'h0, 1'b1);
        apply_stimulus(16'h0FF1, 1'b1, $urandom, 1'b1);

        $display("[TB] randomized accesses");
        for (int n = 0; n < 60; n++) begin
            for (int k = 0; k < 4; k++) slave_word[k] = $urandom;
            cls = $urandom_range(0, 9);
            if (cls <= 3) begin
                i   = $urandom_range(0, 3);
                win = 1 << m_size[i];
                lo  = (m_base[i] / win) * win;
                a   = 16'(lo + $urandom_range(0, win - 1));
            end else if (cls <= 5) begin
                a = 16'(32'h1000 + $urandom_range(0, 32'hEFFF));
            end else if (cls <= 7) begin
                a = ($urandom_range(0, 1) == 0) ? 16'h0FF0 : 16'h0FF1;
            end else begin
                case ($urandom_range(0, 4))
                    0: a = 16'h0110;
                    1: a = 16'h0401;
                    2: a = 16'h0C00;
                    3: a = 16'h0FEF;
                    default: a = 16'h0FF2;
                endcase
            end
            apply_stimulus(a, 1'($urandom), $urandom, 1'b1);
        end

        $display("[TB] reset during wait states");
        apply_stimulus(16'h3000, 1'b0, 32'h0, 1'b1);
        data_sel = 1'b1; data_addr = 16'h0105; data_we = 1'b0; data_to_wr = 32'h0;
        @(posedge clk); #1;
        check_output("rstw_acc_sel", {28'h0, slv_sel}, 32'h2);
        data_sel = 1'b0;
        @(posedge clk); #1;
        #2 rst = 1'b0;
        #1 check_all_zero("rstw");
        m_flag = 1'b0; m_cnt = 0; m_addr = '0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            check_output("rstw_noready", {31'h0, data_ready}, 32'h0);
        end
        rst = 1'b1;
        slave_word[1] = $urandom;
        apply_stimulus(16'h0105, 1'b0, 32'h0, 1'b1);
        apply_stimulus(16'h0FF0, 1'b0, 32'h0, 1'b1);

        $display("[TB] overlapping windows");
        slave_word[0] = $urandom;
        slave_word[1] = $urandom;
        for (int k = 0; k < 4; k++) slv_data_out[k*32 +: 32] = slave_word[k];
        data_sel2 = 1'b1; data_addr = 16'h0100; data_we = 1'b0; data_to_wr = 32'h5A5A5A5A;
        @(posedge clk); #1;
        check_output("ovl_sel", {28'h0, d2_slv_sel}, 32'h1);
        check_output("ovl_addr", {16'h0, d2_slv_addr}, 32'h0100);
        check_output("ovl_we", {31'h0, d2_slv_we}, 32'h0);
        check_output("ovl_wdata", d2_slv_data_in, 32'h5A5A5A5A);
        data_sel2 = 1'b0;
        @(posedge clk); #1;
        check_output("ovl_ready", {31'h0, d2_data_ready}, 32'h1);
        check_output("ovl_rdata", d2_data_to_rd, slave_word[0]);
        @(posedge clk); #1;
        check_output("ovl_idle", {31'h0, d2_data_ready}, 32'h0);
        check_output("ovl_irq", {31'h0, d2_err_irq}, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
